control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter BUS_WIDTH, default 16, SHALL set the width of INSTRUCTION.
REQ-002 Parameter OPCODE_WIDTH, default 4, SHALL set the number of opcode bits, taken from INSTRUCTION[BUS_WIDTH-1 -: OPCODE_WIDTH].
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 CLOCK  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-005 RESET  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 RUN  input  1  SHALL be the clock enable; low freezes the step counter.
REQ-007 INSTRUCTION  input  BUS_WIDTH  SHALL be the instruction register's direct output; opcode is [15:12], operand is [11:0].
REQ-008 FLAG_CARRY, FLAG_ZERO  input  1 each  SHALL be the registered ALU flags.
REQ-009 PC_COUNT, PC_LOAD, PC_ENABLE, MAR_LOAD, RAM_LOAD, RAM_ENABLE, IR_LOAD, IR_ENABLE, A_LOAD, A_ENABLE, B_LOAD, ALU_ENABLE, ALU_SUB, FLAGS_LOAD, OUT_LOAD  output  1 each  SHALL be active-high register and bus controls.
REQ-010 STEP  output  3  SHALL be the current micro-step T0..T5.
REQ-011 HALTED  output  1  SHALL be high while in the halt state.

Function
REQ-012 Control outputs SHALL be a Moore decode of STEP and the latched opcode. While RUN=0, HALTED=1 or RESET=0, they SHALL all be 0.
REQ-013 T0 SHALL assert PC_ENABLE and MAR_LOAD.
REQ-014 T1 SHALL assert RAM_ENABLE, IR_LOAD and PC_COUNT.
REQ-015 From T2 on, the opcode SHALL be decoded from INSTRUCTION, which is valid after the T1 edge.
REQ-016 Opcode 0x0 NOP: T2 SHALL assert nothing, then end.
REQ-017 Opcode 0x1 LDA: T2 SHALL assert IR_ENABLE and MAR_LOAD; T3 SHALL assert RAM_ENABLE and A_LOAD, then end.
REQ-018 Opcode 0x2 ADD: T2 SHALL assert IR_ENABLE and MAR_LOAD; T3 SHALL assert RAM_ENABLE and B_LOAD; T4 SHALL assert ALU_ENABLE, A_LOAD and FLAGS_LOAD, then end.
REQ-019 Opcode 0x3 SUB: SHALL behave as ADD with ALU_SUB also asserted in T4.
REQ-020 Opcode 0x4 STA: T2 SHALL assert IR_ENABLE and MAR_LOAD; T3 SHALL assert A_ENABLE and RAM_LOAD, then end.
REQ-021 Opcode 0x5 LDI: T2 SHALL assert IR_ENABLE and A_LOAD, then end.
REQ-022 Opcode 0x6 JMP: T2 SHALL assert IR_ENABLE and PC_LOAD, then end.
REQ-023 Opcode 0x7 JC: T2 SHALL assert IR_ENABLE always, and PC_LOAD only if FLAG_CARRY=1, then end.
REQ-024 Opcode 0x8 JZ: as JC, using FLAG_ZERO.
REQ-025 Opcode 0xE OUT: T2 SHALL assert A_ENABLE and OUT_LOAD, then end.
REQ-026 Opcode 0xF HLT: the T2 edge SHALL set HALTED=1 and STEP=0; the halt state SHALL be left only via RESET.
REQ-027 Undefined opcodes (0x9-0xD) SHALL execute as NOP.
REQ-028 Step sequencing SHALL follow these rules:
- On the edge leaving an instruction's last step, STEP SHALL return to 0.
- On any other edge, STEP SHALL increment.
- STEP SHALL never exceed 5.
- Cycle counts SHALL be: NOP/LDI/JMP/JC/JZ/OUT = 3; LDA/STA = 4; ADD/SUB = 5.
REQ-029 At most one *_ENABLE output SHALL be high in any cycle.
REQ-030 Bus drive and load SHALL occur in the same step, with the loading register capturing on that step's closing edge.
REQ-031 RUN=0 mid-instruction SHALL hold STEP and the opcode. On RUN=1, execution SHALL resume at the same step with identical outputs.
REQ-032 The jump condition SHALL be evaluated combinationally during T2. A flag change in T2 SHALL affect PC_LOAD in that same cycle.

Reset
REQ-033 RESET=0 SHALL immediately, without a clock, force STEP=0, HALTED=0 and all control outputs to 0.
REQ-034 After RESET releases, the first rising edge with RUN=1 SHALL leave STEP=0 in T0. T0 controls SHALL be visible in the cycle before that edge.
REQ-035 Reset asserted mid-instruction SHALL abandon the instruction, with no partial loads after assertion.

Verification
REQ-036 Reset then RUN=1, INSTRUCTION=0x5007 (LDI) -> T0 PC_ENABLE+MAR_LOAD; T1 RAM_ENABLE+IR_LOAD+PC_COUNT; T2 IR_ENABLE+A_LOAD; STEP sequence 0,1,2,0.
REQ-037 INSTRUCTION=0x2010 (ADD) -> STEP sequence 0,1,2,3,4,0; FLAGS_LOAD high only in T4; ALU_SUB=0. Repeat with 0x3010 -> ALU_SUB=1 only in T4.
REQ-038 JC 0x7020 with FLAG_CARRY=0 -> no PC_LOAD. With FLAG_CARRY=1 -> PC_LOAD=1 in T2. JZ 0x8020 checked likewise against FLAG_ZERO.
REQ-039 HLT 0xF000 -> HALTED=1 after the T2 edge; all controls 0 for 20 cycles; async RESET pulse -> HALTED=0, STEP=0.
REQ-040 RUN dropped for 3 cycles at STEP=3 of ADD -> STEP stays 3 and controls stay 0; on RUN=1, T3 controls reappear and the instruction completes in 2 more cycles.
REQ-041 Random instruction stream with an assertion that at most one *_ENABLE is high per cycle -> no violation; opcode 0xB -> NOP timing.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for a simple 8-bit style CPU: steps T0..T5
// and decodes the opcode into Moore register/bus control strobes.
module control_sequencer #(
  parameter int BUS_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [BUS_WIDTH-1:0] instruction,
  input  logic                 flag_carry,
  input  logic                 flag_zero,
  output logic                 pc_count,
  output logic                 pc_load,
  output logic                 pc_enable,
  output logic                 mar_load,
  output logic                 ram_load,
  output logic                 ram_enable,
  output logic                 ir_load,
  output logic                 ir_enable,
  output logic                 a_load,
  output logic                 a_enable,
  output logic                 b_load,
  output logic                 alu_enable,
  output logic                 alu_sub,
  output logic                 flags_load,
  output logic                 out_load,
  output logic [2:0]           step,
  output logic                 halted
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  step_e                   step_q, step_d, last_step;
  logic                    halted_q, halted_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d, opcode;
  logic                    active;
  logic                    unused_operand;

  assign unused_operand = ^instruction[BUS_WIDTH-OPCODE_WIDTH-1:0];

  // The IR is only valid after the T1 edge, so T2 decodes it live and later steps use the latched copy.
  always_comb begin
    opcode   = (step_q == T2) ? instruction[BUS_WIDTH-1 -: OPCODE_WIDTH] : opcode_q;
    opcode_d = (run && step_q == T2) ? opcode : opcode_q;

    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase

    step_d   = step_q;
    halted_d = halted_q;
    if (run && !halted_q) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halted_d = 1'b1;
        step_d   = T0;
      end else if (step_q >= last_step || step_q >= T5) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
      opcode_q <= '0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
      opcode_q <= opcode_d;
    end
  end

  // Reset is folded in combinationally so the strobes drop without waiting for a clock.
  assign active = run && reset && !halted_q;
  assign step   = step_q;
  assign halted = halted_q;

  always_comb begin
    pc_count   = 1'b0;
    pc_load    = 1'b0;
    pc_enable  = 1'b0;
    mar_load   = 1'b0;
    ram_load   = 1'b0;
    ram_enable = 1'b0;
    ir_load    = 1'b0;
    ir_enable  = 1'b0;
    a_load     = 1'b0;
    a_enable   = 1'b0;
    b_load     = 1'b0;
    alu_enable = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    if (active) begin
      case (step_q)
        T0: begin
          pc_enable = 1'b1;
          mar_load  = 1'b1;
        end
        T1: begin
          ram_enable = 1'b1;
          ir_load    = 1'b1;
          pc_count   = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_enable = 1'b1;
              mar_load  = 1'b1;
            end
            OP_LDI: begin
              ir_enable = 1'b1;
              a_load    = 1'b1;
            end
            OP_JMP: begin
              ir_enable = 1'b1;
              pc_load   = 1'b1;
            end
            OP_JC: begin
              ir_enable = 1'b1;
              pc_load   = flag_carry;
            end
            OP_JZ: begin
              ir_enable = 1'b1;
              pc_load   = flag_zero;
            end
            OP_OUT: begin
              a_enable = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_enable = 1'b1;
              a_load     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_enable = 1'b1;
              b_load     = 1'b1;
            end
            OP_STA: begin
              a_enable = 1'b1;
              ram_load = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_enable = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: per-step control words,
// conditional jumps, run pause, async reset, halt, and a random stream.
module tb_control_sequencer;

  localparam logic [14:0] C_PC_COUNT   = 15'h4000;
  localparam logic [14:0] C_PC_LOAD    = 15'h2000;
  localparam logic [14:0] C_PC_ENABLE  = 15'h1000;
  localparam logic [14:0] C_MAR_LOAD   = 15'h0800;
  localparam logic [14:0] C_RAM_LOAD   = 15'h0400;
  localparam logic [14:0] C_RAM_ENABLE = 15'h0200;
  localparam logic [14:0] C_IR_LOAD    = 15'h0100;
  localparam logic [14:0] C_IR_ENABLE  = 15'h0080;
  localparam logic [14:0] C_A_LOAD     = 15'h0040;
  localparam logic [14:0] C_A_ENABLE   = 15'h0020;
  localparam logic [14:0] C_B_LOAD     = 15'h0010;
  localparam logic [14:0] C_ALU_ENABLE = 15'h0008;
  localparam logic [14:0] C_ALU_SUB    = 15'h0004;
  localparam logic [14:0] C_FLAGS_LOAD = 15'h0002;
  localparam logic [14:0] C_OUT_LOAD   = 15'h0001;

  localparam logic [14:0] FETCH0   = C_PC_ENABLE | C_MAR_LOAD;
  localparam logic [14:0] FETCH1   = C_RAM_ENABLE | C_IR_LOAD | C_PC_COUNT;
  localparam logic [14:0] ADDR_T2  = C_IR_ENABLE | C_MAR_LOAD;
  localparam logic [14:0] EN_MASK  = C_PC_ENABLE | C_RAM_ENABLE | C_IR_ENABLE |
                                     C_A_ENABLE | C_ALU_ENABLE;
  localparam logic [14:0] ADD_T3   = C_RAM_ENABLE | C_B_LOAD;
  localparam logic [14:0] ADD_T4   = C_ALU_ENABLE | C_A_LOAD | C_FLAGS_LOAD;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic        flag_carry, flag_zero;
  logic        pc_count, pc_load, pc_enable, mar_load, ram_load, ram_enable;
  logic        ir_load, ir_enable, a_load, a_enable, b_load, alu_enable;
  logic        alu_sub, flags_load, out_load;
  logic [2:0]  step;
  logic        halted;
  logic [14:0] ctrl;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  control_sequencer #(.BUS_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_count(pc_count), .pc_load(pc_load), .pc_enable(pc_enable),
    .mar_load(mar_load), .ram_load(ram_load), .ram_enable(ram_enable),
    .ir_load(ir_load), .ir_enable(ir_enable), .a_load(a_load),
    .a_enable(a_enable), .b_load(b_load), .alu_enable(alu_enable),
    .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .step(step), .halted(halted)
  );

  assign ctrl = {pc_count, pc_load, pc_enable, mar_load, ram_load, ram_enable,
                 ir_load, ir_enable, a_load, a_enable, b_load, alu_enable,
                 alu_sub, flags_load, out_load};

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [15:0] instr,
                               input logic c, input logic z);
    run         = r;
    instruction = instr;
    flag_carry  = c;
    flag_zero   = z;
  endtask

  task automatic nextCycle();
    @(negedge clock);
    #1;
  endtask

  // Starts and ends mid-cycle in T0; checks every step and the return to T0.
  task automatic runInstr(input string name, input logic [15:0] instr, input int n,
                          input logic c, input logic z, input logic [14:0] exp [5]);
    applyStimulus(1'b1, instr, c, z);
    for (int i = 0; i < n; i++) begin
      checkOutput({name, "_step"}, 32'(step), 32'(i));
      checkOutput({name, "_ctrl"}, 32'(ctrl), 32'(exp[i]));
      nextCycle();
    end
    checkOutput({name, "_end_step"}, 32'(step), 32'd0);
    checkOutput({name, "_end_ctrl"}, 32'(ctrl), 32'(FETCH0));
  endtask

  function automatic int expectedLength(input logic [3:0] op);
    if (op == 4'h1 || op == 4'h4) return 4;
    if (op == 4'h2 || op == 4'h3) return 5;
    return 3;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] op;
    int         cycles;

    reset = 1'b0;
    applyStimulus(1'b1, 16'h5007, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    checkOutput("reset_step", 32'(step), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_ctrl", 32'(ctrl), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("release_ctrl", 32'(ctrl), 32'(FETCH0));

    runInstr("ldi", 16'h5007, 3, 1'b0, 1'b0, '{FETCH0, FETCH1, C_IR_ENABLE | C_A_LOAD, 15'h0, 15'h0});
    runInstr("add", 16'h2010, 5, 1'b0, 1'b0, '{FETCH0, FETCH1, ADDR_T2, ADD_T3, ADD_T4});
    runInstr("sub", 16'h3010, 5, 1'b0, 1'b0, '{FETCH0, FETCH1, ADDR_T2, ADD_T3, ADD_T4 | C_ALU_SUB});
    runInstr("lda", 16'h1020, 4, 1'b0, 1'b0, '{FETCH0, FETCH1, ADDR_T2, C_RAM_ENABLE | C_A_LOAD, 15'h0});
    runInstr("sta", 16'h4020, 4, 1'b0, 1'b0, '{FETCH0, FETCH1, ADDR_T2, C_A_ENABLE | C_RAM_LOAD, 15'h0});
    runInstr("jmp", 16'h6030, 3, 1'b0, 1'b0, '{FETCH0, FETCH1, C_IR_ENABLE | C_PC_LOAD, 15'h0, 15'h0});
    runInstr("out", 16'hE000, 3, 1'b0, 1'b0, '{FETCH0, FETCH1, C_A_ENABLE | C_OUT_LOAD, 15'h0, 15'h0});
    runInstr("nop", 16'h0000, 3, 1'b0, 1'b0, '{FETCH0, FETCH1, 15'h0, 15'h0, 15'h0});
    runInstr("undef_b", 16'hB123, 3, 1'b1, 1'b1, '{FETCH0, FETCH1, 15'h0, 15'h0, 15'h0});
    runInstr("jc_nc", 16'h7020, 3, 1'b0, 1'b1, '{FETCH0, FETCH1, C_IR_ENABLE, 15'h0, 15'h0});
    runInstr("jc_c", 16'h7020, 3, 1'b1, 1'b0, '{FETCH0, FETCH1, C_IR_ENABLE | C_PC_LOAD, 15'h0, 15'h0});
    runInstr("jz_nz", 16'h8020, 3, 1'b1, 1'b0, '{FETCH0, FETCH1, C_IR_ENABLE, 15'h0, 15'h0});
    runInstr("jz_z", 16'h8020, 3, 1'b0, 1'b1, '{FETCH0, FETCH1, C_IR_ENABLE | C_PC_LOAD, 15'h0, 15'h0});

    // Carry rises in the middle of T2 and must reach pc_load without a clock.
    applyStimulus(1'b1, 16'h7020, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("jc_live_before", 32'(ctrl), 32'(C_IR_ENABLE));
    flag_carry = 1'b1;
    #1;
    checkOutput("jc_live_after", 32'(ctrl), 32'(C_IR_ENABLE | C_PC_LOAD));
    nextCycle();
    checkOutput("jc_live_end", 32'(step), 32'd0);

    // Pause ADD at T3 for three cycles, then resume.
    applyStimulus(1'b1, 16'h2010, 1'b0, 1'b0);
    repeat (3) nextCycle();
    checkOutput("pause_t3_ctrl", 32'(ctrl), 32'(ADD_T3));
    run = 1'b0;
    #1;
    checkOutput("pause_ctrl_off", 32'(ctrl), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("pause_step", 32'(step), 32'd3);
      checkOutput("pause_ctrl", 32'(ctrl), 32'd0);
    end
    run = 1'b1;
    #1;
    checkOutput("resume_t3_ctrl", 32'(ctrl), 32'(ADD_T3));
    nextCycle();
    checkOutput("resume_t4_step", 32'(step), 32'd4);
    checkOutput("resume_t4_ctrl", 32'(ctrl), 32'(ADD_T4));
    nextCycle();
    checkOutput("resume_end_step", 32'(step), 32'd0);

    // Async reset in the middle of an ADD.
    repeat (3) nextCycle();
    checkOutput("midrst_pre_step", 32'(step), 32'd3);
    reset = 1'b0;
    #1;
    checkOutput("midrst_step", 32'(step), 32'd0);
    checkOutput("midrst_ctrl", 32'(ctrl), 32'd0);
    nextCycle();
    checkOutput("midrst_hold_ctrl", 32'(ctrl), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_release_ctrl", 32'(ctrl), 32'(FETCH0));

    // Random stream: one bus driver per cycle and opcode-dependent length.
    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(0, 14));
      applyStimulus(1'b1, {op, 12'($urandom)}, 1'($urandom), 1'($urandom));
      cycles = 0;
      do begin
        checkOutput("stream_one_enable", 32'($countones(ctrl & EN_MASK) <= 1), 32'd1);
        nextCycle();
        cycles++;
      end while (step != 3'd0 && cycles < 8);
      checkOutput("stream_length", 32'(cycles), 32'(expectedLength(op)));
    end

    // Halt, stay halted, leave only via async reset.
    applyStimulus(1'b1, 16'hF000, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("hlt_t2_ctrl", 32'(ctrl), 32'd0);
    checkOutput("hlt_t2_halted", 32'(halted), 32'd0);
    nextCycle();
    checkOutput("hlt_halted", 32'(halted), 32'd1);
    checkOutput("hlt_step", 32'(step), 32'd0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("hlt_hold_ctrl", 32'(ctrl), 32'd0);
      checkOutput("hlt_hold_halted", 32'(halted), 32'd1);
      nextCycle();
    end
    reset = 1'b0;
    #1;
    checkOutput("hlt_rst_halted", 32'(halted), 32'd0);
    checkOutput("hlt_rst_step", 32'(step), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("hlt_release_ctrl", 32'(ctrl), 32'(FETCH0));
    runInstr("post_hlt_ldi", 16'h5001, 3, 1'b0, 1'b0, '{FETCH0, FETCH1, C_IR_ENABLE | C_A_LOAD, 15'h0, 15'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
